letter_tracker: RTL and testbench

- Consumes letters from the falling-letter generator and keeps up to SLOTS letters on screen.
- Moves each active letter down by its speed on every frame tick.
- Removes a letter when the player types it (hit) or when it reaches the bottom of the screen (miss).
- Sits between the generator and keyboard decoder on the input side and the VGA renderer and score display on the output side.

---
 rtl/letter_tracker.sv | 175 +++++++++++++++++
 tb/tb_letter_tracker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/letter_tracker.sv
// Falling-letter slot tracker: accepts spawned letters, advances them each frame,
// and retires them on a correct keystroke (hit) or on reaching the bottom row (miss).
module letter_tracker #(
  parameter int          SLOTS   = 8,
  parameter logic [8:0]  X_MAX   = 9'd470,
  parameter int          SCORE_W = 16,
  localparam int         IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  // generator side
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [7:0]         spawn_ch,
  input  logic [2:0]         spawn_speed,
  input  logic [8:0]         spawn_x,
  input  logic [9:0]         spawn_y,
  // timing and keyboard
  input  logic               frame_tick,
  input  logic               key_valid,
  input  logic [7:0]         key_ch,
  // renderer read port
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_active,
  output logic [7:0]         rd_ch,
  output logic [8:0]         rd_x,
  output logic [9:0]         rd_y,
  // score side
  output logic               hit,
  output logic               miss,
  output logic               wrong,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         miss_count
);

  typedef struct packed {
    logic       active;
    logic [7:0] ch;
    logic [2:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } slot_t;

  slot_t slot_q [SLOTS];
  slot_t slot_d [SLOTS];

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               key_found;
  logic [IDX_W-1:0]   key_idx;
  logic [8:0]         best_x;
  logic               key_hit;
  logic               key_wrong;
  logic               spawn_fire;
  logic               any_miss;
  logic [9:0]         x_next;
  logic [2:0]         speed_fix;
  slot_t              rd_slot;

  logic               hit_q;
  logic               miss_q;
  logic               wrong_q;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]         miss_count_q;

  // Lowest-index free slot, taken from the registered state only, so a slot
  // released this cycle is not reused until the next one.
  // NOTE: every variable driven in always_comb gets a default up front; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!slot_q[i].active && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = free_found;
  assign spawn_fire  = spawn_valid && free_found;
  assign speed_fix   = (spawn_speed == 3'd0) ? 3'd1 : spawn_speed;

  // Key winner: the matching letter closest to the bottom; strict '>' keeps
  // the lowest index on equal rows.
  always_comb begin
    key_found = 1'b0;
    key_idx   = '0;
    best_x    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q[i].active && (slot_q[i].ch == key_ch) &&
          (!key_found || (slot_q[i].x > best_x))) begin
        key_found = 1'b1;
        key_idx   = IDX_W'(i);
        best_x    = slot_q[i].x;
      end
    end
  end

  assign key_hit   = key_valid && key_found;
  assign key_wrong = key_valid && !key_found;

  // Per-slot next state. A hit clears its slot before the tick is considered,
  // so a letter typed on its final frame scores rather than misses.
  always_comb begin
    any_miss = 1'b0;
    x_next   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      x_next    = {1'b0, slot_q[i].x} + {7'd0, slot_q[i].speed};
      if (slot_q[i].active) begin
        if (key_hit && (key_idx == IDX_W'(i))) begin
          slot_d[i] = '0;
        end else if (frame_tick) begin
          if (x_next >= {1'b0, X_MAX}) begin
            slot_d[i] = '0;
            any_miss  = 1'b1;
          end else begin
            slot_d[i].x = x_next[8:0];
          end
        end
      end
    end
    // The chosen slot was inactive, so neither the tick nor the key touched it.
    if (spawn_fire) begin
      slot_d[free_idx] = '{active: 1'b1, ch: spawn_ch, speed: speed_fix,
                           x: spawn_x, y: spawn_y};
    end
  end

  // NOTE: the slot array is reset explicitly because a cleared slot must read
  // back as all-zero; a plain RAM would not give that.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      wrong_q      <= 1'b0;
      score_q      <= '0;
      miss_count_q <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      hit_q   <= key_hit;
      miss_q  <= any_miss;
      wrong_q <= key_wrong;
      if (key_hit && (score_q != {SCORE_W{1'b1}})) begin
        score_q <= score_q + SCORE_W'(1);
      end
      if (any_miss && (miss_count_q != 8'hFF)) begin
        miss_count_q <= miss_count_q + 8'd1;
      end
    end
  end

  assign hit        = hit_q;
  assign miss       = miss_q;
  assign wrong      = wrong_q;
  assign score      = score_q;
  assign miss_count = miss_count_q;

  // Renderer view; fields are masked so a free slot always reads as zero.
  assign rd_slot   = slot_q[rd_idx];
  assign rd_active = rd_slot.active;
  assign rd_ch     = rd_slot.active ? rd_slot.ch : 8'd0;
  assign rd_x      = rd_slot.active ? rd_slot.x  : 9'd0;
  assign rd_y      = rd_slot.active ? rd_slot.y  : 10'd0;

endmodule

// File: tb/tb_letter_tracker.sv
// Directed bench for letter_tracker: fill, motion/miss, key priority, hit-vs-miss,
// slot reuse timing, miss saturation and asynchronous reset.
module tb_letter_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [7:0]  spawn_ch;
  logic [2:0]  spawn_speed;
  logic [8:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic        frame_tick;
  logic        key_valid;
  logic [7:0]  key_ch;
  logic [2:0]  rd_idx;
  logic        rd_active;
  logic [7:0]  rd_ch;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic        hit;
  logic        miss;
  logic        wrong;
  logic [15:0] score;
  logic [7:0]  miss_count;

  int checks   = 0;
  int failures = 0;

  letter_tracker #(.SLOTS(8), .X_MAX(9'd470), .SCORE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_ch(spawn_ch),
    .spawn_speed(spawn_speed), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .frame_tick(frame_tick), .key_valid(key_valid), .key_ch(key_ch),
    .rd_idx(rd_idx), .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .hit(hit), .miss(miss), .wrong(wrong), .score(score), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (inputs change on the falling edge) ----------
  task automatic idle_inputs();
    spawn_valid = 1'b0; spawn_ch = 8'd0; spawn_speed = 3'd0;
    spawn_x = 9'd0; spawn_y = 10'd0;
    frame_tick = 1'b0; key_valid = 1'b0; key_ch = 8'd0;
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic set_spawn(input logic [7:0] ch, input logic [2:0] sp,
                           input logic [8:0] x, input logic [9:0] y);
    spawn_valid = 1'b1; spawn_ch = ch; spawn_speed = sp; spawn_x = x; spawn_y = y;
  endtask

  task automatic spawn(input logic [7:0] ch, input logic [2:0] sp,
                       input logic [8:0] x, input logic [9:0] y);
    set_spawn(ch, sp, x, y);
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
  endtask

  task automatic key(input logic [7:0] ch);
    key_valid = 1'b1; key_ch = ch;
    step();
  endtask

  task automatic peek(input int idx);
    rd_idx = 3'(idx);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_alpha();
    for (int i = 0; i < 8; i++) spawn(8'(8'h41 + i), 3'd1, 9'd0, 10'(i * 10));
  endtask

  // ---------------- scenarios --------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    rd_idx = 3'd0;
    #3;
    checks++; if (spawn_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", spawn_ready); end
    checks++; if ({hit, miss, wrong} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b want 000", {hit, miss, wrong}); end
    checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (miss_count !== 8'd0) begin failures++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    for (int i = 0; i < 8; i++) begin
      peek(i);
      checks++; if ({rd_active, rd_ch, rd_x, rd_y} !== 28'd0) begin failures++; $display("FAIL reset_slot%0d: got %h want 0", i, {rd_active, rd_ch, rd_x, rd_y}); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    fill_alpha();
    for (int i = 0; i < 8; i++) begin
      peek(i);
      checks++; if ({rd_active, rd_ch, rd_y} !== {1'b1, 8'(8'h41 + i), 10'(i * 10)}) begin failures++; $display("FAIL fill_slot%0d: got act=%b ch=%h y=%0d want act=1 ch=%h y=%0d", i, rd_active, rd_ch, rd_y, 8'(8'h41 + i), i * 10); end
    end
    checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full: got %b want 0", spawn_ready); end
    spawn("Z", 3'd1, 9'd0, 10'd0);
    for (int i = 0; i < 8; i++) begin
      peek(i);
      checks++; if (rd_ch !== 8'(8'h41 + i)) begin failures++; $display("FAIL fill_ninth_slot%0d: got %h want %h", i, rd_ch, 8'(8'h41 + i)); end
    end
  endtask

  task automatic test_motion_miss();
    apply_reset();
    spawn("Q", 3'd3, 9'd460, 10'd7);
    tick(); peek(0);
    checks++; if (rd_x !== 9'd463) begin failures++; $display("FAIL motion_t1: got %0d want 463", rd_x); end
    tick(); peek(0);
    checks++; if (rd_x !== 9'd466) begin failures++; $display("FAIL motion_t2: got %0d want 466", rd_x); end
    tick(); peek(0);
    checks++; if ({rd_active, rd_x} !== {1'b1, 9'd469}) begin failures++; $display("FAIL motion_t3: got act=%b x=%0d want act=1 x=469", rd_active, rd_x); end
    tick(); peek(0);
    checks++; if ({rd_active, rd_x} !== {1'b0, 9'd0}) begin failures++; $display("FAIL miss_clear: got act=%b x=%0d want act=0 x=0", rd_active, rd_x); end
    checks++; if ({miss, hit, wrong} !== 3'b100) begin failures++; $display("FAIL miss_pulse: got miss/hit/wrong=%b want 100", {miss, hit, wrong}); end
    checks++; if (miss_count !== 8'd1) begin failures++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
    step();
    checks++; if (miss !== 1'b0) begin failures++; $display("FAIL miss_one_cycle: got %b want 0", miss); end
  endtask

  task automatic test_spawn_tick();
    apply_reset();
    spawn("S", 3'd2, 9'd100, 10'd1);
    frame_tick = 1'b1;
    spawn("P", 3'd0, 9'd10, 10'd2);
    peek(0);
    checks++; if (rd_x !== 9'd102) begin failures++; $display("FAIL spawn_tick_old: got %0d want 102", rd_x); end
    peek(1);
    checks++; if ({rd_active, rd_ch, rd_x} !== {1'b1, 8'h50, 9'd10}) begin failures++; $display("FAIL spawn_tick_new: got act=%b ch=%h x=%0d want act=1 ch=50 x=10", rd_active, rd_ch, rd_x); end
    tick(); peek(1);
    checks++; if (rd_x !== 9'd11) begin failures++; $display("FAIL speed0_as1: got %0d want 11", rd_x); end
  endtask

  task automatic test_key_priority();
    apply_reset();
    spawn("A", 3'd1, 9'd0, 10'd0);
    spawn("B", 3'd1, 9'd0, 10'd0);
    spawn("K", 3'd1, 9'd100, 10'd0);
    spawn("C", 3'd1, 9'd0, 10'd0);
    spawn("D", 3'd1, 9'd0, 10'd0);
    spawn("K", 3'd1, 9'd200, 10'd0);
    key("K");
    checks++; if ({hit, wrong, score} !== {1'b1, 1'b0, 16'd1}) begin failures++; $display("FAIL key1: got hit=%b wrong=%b score=%0d want 1 0 1", hit, wrong, score); end
    peek(5);
    checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL key1_slot5: got %b want 0", rd_active); end
    peek(2);
    checks++; if ({rd_active, rd_x} !== {1'b1, 9'd100}) begin failures++; $display("FAIL key1_slot2: got act=%b x=%0d want 1 100", rd_active, rd_x); end
    key("K"); peek(2);
    checks++; if ({rd_active, hit, score} !== {1'b0, 1'b1, 16'd2}) begin failures++; $display("FAIL key2: got act=%b hit=%b score=%0d want 0 1 2", rd_active, hit, score); end
    key("Z");
    checks++; if ({wrong, hit, score} !== {1'b1, 1'b0, 16'd2}) begin failures++; $display("FAIL key_wrong: got wrong=%b hit=%b score=%0d want 1 0 2", wrong, hit, score); end
    step();
    checks++; if (wrong !== 1'b0) begin failures++; $display("FAIL wrong_one_cycle: got %b want 0", wrong); end
    spawn("T", 3'd1, 9'd50, 10'd0);
    spawn("T", 3'd1, 9'd50, 10'd0);
    key("T");
    peek(2);
    checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL tie_low_cleared: got %b want 0", rd_active); end
    peek(5);
    checks++; if ({rd_active, rd_ch} !== {1'b1, 8'h54}) begin failures++; $display("FAIL tie_high_kept: got act=%b ch=%h want 1 54", rd_active, rd_ch); end
  endtask

  task automatic test_hit_beats_miss();
    apply_reset();
    spawn("M", 3'd5, 9'd468, 10'd0);
    frame_tick = 1'b1;
    key("M");
    checks++; if ({hit, miss, wrong, miss_count} !== {3'b100, 8'd0}) begin failures++; $display("FAIL hit_vs_miss: got hit/miss/wrong=%b mc=%0d want 100 0", {hit, miss, wrong}, miss_count); end
    spawn("M", 3'd5, 9'd468, 10'd0);
    spawn("N", 3'd5, 9'd468, 10'd0);
    spawn("O", 3'd1, 9'd0, 10'd0);
    frame_tick = 1'b1;
    key("M");
    checks++; if ({hit, miss, miss_count} !== {2'b11, 8'd1}) begin failures++; $display("FAIL hit_and_other_miss: got hit=%b miss=%b mc=%0d want 1 1 1", hit, miss, miss_count); end
    peek(1);
    checks++; if (rd_active !== 1'b0) begin failures++; $display("FAIL other_missed_slot: got %b want 0", rd_active); end
    peek(2);
    checks++; if (rd_x !== 9'd1) begin failures++; $display("FAIL other_moved_slot: got %0d want 1", rd_x); end
  endtask

  task automatic test_full_free();
    apply_reset();
    fill_alpha();
    set_spawn("Z", 3'd2, 9'd5, 10'd9);
    key("D");
    peek(3);
    checks++; if ({hit, rd_active} !== 2'b10) begin failures++; $display("FAIL free_same_cycle: got hit=%b act=%b want 1 0", hit, rd_active); end
    checks++; if (spawn_ready !== 1'b1) begin failures++; $display("FAIL free_ready: got %b want 1", spawn_ready); end
    spawn("Z", 3'd2, 9'd5, 10'd9);
    peek(3);
    checks++; if ({rd_active, rd_ch, rd_x, rd_y} !== {1'b1, 8'h5A, 9'd5, 10'd9}) begin failures++; $display("FAIL refill_slot3: got act=%b ch=%h x=%0d y=%0d want 1 5a 5 9", rd_active, rd_ch, rd_x, rd_y); end
    checks++; if (spawn_ready !== 1'b0) begin failures++; $display("FAIL refill_ready: got %b want 0", spawn_ready); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 300; i++) begin
      spawn("W", 3'd1, 9'd469, 10'd0);
      tick();
      if (i == 255) begin
        checks++; if (miss_count !== 8'd255) begin failures++; $display("FAIL miss_count_255: got %0d want 255", miss_count); end
      end
    end
    checks++; if (miss_count !== 8'd255) begin failures++; $display("FAIL miss_count_sat: got %0d want 255", miss_count); end
  endtask

  task automatic test_async_reset();
    spawn("H", 3'd1, 9'd0, 10'd0);
    key_valid = 1'b1; key_ch = "H";
    @(posedge clk);
    #2;
    checks++; if ({hit, score} !== {1'b1, 16'd1}) begin failures++; $display("FAIL pre_reset: got hit=%b score=%0d want 1 1", hit, score); end
    rst_n = 1'b0;
    rd_idx = 3'd0;
    #1;
    checks++; if ({hit, miss, wrong, score, miss_count} !== 27'd0) begin failures++; $display("FAIL async_reset_outputs: got hit=%b miss=%b wrong=%b score=%0d mc=%0d want all 0", hit, miss, wrong, score, miss_count); end
    checks++; if ({rd_active, spawn_ready} !== 2'b01) begin failures++; $display("FAIL async_reset_slots: got act=%b ready=%b want 0 1", rd_active, spawn_ready); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_motion_miss();
    test_spawn_tick();
    test_key_priority();
    test_hit_beats_miss();
    test_full_free();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
